// File: rtl/tiny_proc_run_ctrl.sv
// Run controller for a tiny core: program RAM, run/step/halt/reset FSM.
// Define RUN_CTRL_BREAKPOINT_EN to compile in the PC breakpoint.
module tiny_proc_run_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_p,
    input  logic             host_we,
    input  logic [3:0]       host_addr,
    input  logic [7:0]       host_data,
    output logic             host_ack,
    output logic             host_nack,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_halt,
    input  logic             cmd_reset,
    input  logic [3:0]       core_fetch_addr,
    output logic [7:0]       core_inst,
    input  logic             core_retire,
    input  logic [3:0]       core_next_pc,
    output logic             core_en,
    output logic             core_rst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted_bp,
    input  logic [3:0]       bp_addr,
    input  logic             bp_en
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        CRST = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic             crst_cnt_q, crst_cnt_d;
    logic             core_en_q, core_en_d;
    logic             core_rst_q, core_rst_d;
    logic             host_ack_q, host_ack_d;
    logic             host_nack_q, host_nack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ram_q [16];
    logic [7:0]       ram_d [16];
    logic             bp_hit;
    logic             bp_set;
    logic             bp_clr;

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic halted_bp_q, halted_bp_d;

    assign bp_hit = bp_en && (core_next_pc == bp_addr) && (state_q == RUN);

    always_comb begin
        halted_bp_d = halted_bp_q;
        if (bp_clr) halted_bp_d = 1'b0;
        if (bp_set) halted_bp_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) halted_bp_q <= 1'b0;
        else         halted_bp_q <= halted_bp_d;
    end

    assign halted_bp = halted_bp_q;
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_en, bp_addr, core_next_pc, bp_set, bp_clr};
    assign halted_bp = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        crst_cnt_d  = crst_cnt_q;
        bp_set      = 1'b0;
        bp_clr      = 1'b0;
        ram_d       = ram_q;
        host_ack_d  = host_we && (state_q == HALT);
        host_nack_d = host_we && (state_q != HALT);
        if (host_ack_d) ram_d[host_addr] = host_data;

        if (cmd_reset) begin
            state_d    = CRST;
            crst_cnt_d = 1'b0;
            cnt_d      = '0;
            pend_d     = 1'b0;
            bp_clr     = 1'b1;
        end else begin
            unique case (state_q)
                HALT: begin
                    if (!cmd_halt && (cmd_step || cmd_run)) begin
                        state_d = cmd_step ? STEP : RUN;
                        pend_d  = 1'b0;
                        bp_clr  = 1'b1;
                    end
                end
                RUN, STEP: begin
                    if (core_retire) begin
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                        // Stop only at the retire edge: instruction boundary.
                        if (state_q == STEP || cmd_halt || pend_q || bp_hit) begin
                            state_d = HALT;
                            pend_d  = 1'b0;
                        end
                        bp_set = bp_hit;
                    end else if (cmd_halt) begin
                        pend_d = 1'b1;
                    end
                end
                CRST: begin
                    if (crst_cnt_q) state_d = HALT;
                    else            crst_cnt_d = 1'b1;
                end
                default: state_d = HALT;
            endcase
        end

        core_en_d  = (state_d != HALT);
        core_rst_d = (state_d == CRST);
    end

    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= HALT;
            pend_q      <= 1'b0;
            crst_cnt_q  <= 1'b0;
            core_en_q   <= 1'b0;
            core_rst_q  <= 1'b1;
            host_ack_q  <= 1'b0;
            host_nack_q <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            crst_cnt_q  <= crst_cnt_d;
            core_en_q   <= core_en_d;
            core_rst_q  <= core_rst_d;
            host_ack_q  <= host_ack_d;
            host_nack_q <= host_nack_d;
            cnt_q       <= cnt_d;
            ram_q       <= ram_d;
        end
    end

    assign core_inst   = ram_q[core_fetch_addr];
    assign state       = state_q;
    assign core_en     = core_en_q;
    assign core_rst    = core_rst_q;
    assign host_ack    = host_ack_q;
    assign host_nack   = host_nack_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_tiny_proc_run_ctrl.sv
// Scoreboard bench for tiny_proc_run_ctrl with a behavioural reference model.
// Directed scenarios followed by randomized commands, writes and retires.
module tb_tiny_proc_run_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_CRST  = 3;

    logic             clock;
    logic             reset_p;
    logic             host_we;
    logic [3:0]       host_addr;
    logic [7:0]       host_data;
    logic             host_ack;
    logic             host_nack;
    logic             cmd_run, cmd_step, cmd_halt, cmd_reset;
    logic [3:0]       core_fetch_addr;
    logic [7:0]       core_inst;
    logic             core_retire;
    logic [3:0]       core_next_pc;
    logic             core_en;
    logic             core_rst;
    logic [1:0]       state;
    logic [CNT_W-1:0] retired_cnt;
    logic             halted_bp;
    logic [3:0]       bp_addr;
    logic             bp_en;

    tiny_proc_run_ctrl #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset_p(reset_p),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .host_nack(host_nack),
        .cmd_run(cmd_run), .cmd_step(cmd_step),
        .cmd_halt(cmd_halt), .cmd_reset(cmd_reset),
        .core_fetch_addr(core_fetch_addr), .core_inst(core_inst),
        .core_retire(core_retire), .core_next_pc(core_next_pc),
        .core_en(core_en), .core_rst(core_rst),
        .state(state), .retired_cnt(retired_cnt), .halted_bp(halted_bp),
        .bp_addr(bp_addr), .bp_en(bp_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int st;
        int en;
        int rst;
        int ack;
        int nack;
        int cnt;
        int bp;
        int inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int   m_mode = M_HALT;
    int   m_cnt  = 0;
    bit   m_pend = 0;
    bit   m_bp   = 0;
    int   m_rst_left = 0;
    int   m_ram[16];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bp_feature();
`ifdef RUN_CTRL_BREAKPOINT_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    // Apply one cycle of stimulus and push the model's post-edge view.
    task automatic drive(input bit rst, input bit halt, input bit step,
                         input bit run, input bit we, input int addr,
                         input int data, input bit ret, input int npc,
                         input int fa, input bit bpe, input int bpa);
        exp_t e;
        bit hit;
        cmd_reset = rst; cmd_halt = halt; cmd_step = step; cmd_run = run;
        host_we = we; host_addr = 4'(addr); host_data = 8'(data);
        core_retire = ret; core_next_pc = 4'(npc);
        core_fetch_addr = 4'(fa); bp_en = bpe; bp_addr = 4'(bpa);

        e.ack  = (we && m_mode == M_HALT) ? 1 : 0;
        e.nack = (we && m_mode != M_HALT) ? 1 : 0;
        if (e.ack == 1) m_ram[addr] = data;

        if (rst) begin
            m_mode = M_CRST; m_rst_left = 2;
            m_cnt = 0; m_pend = 0; m_bp = 0;
        end else if (m_mode == M_CRST) begin
            m_rst_left--;
            if (m_rst_left == 0) m_mode = M_HALT;
        end else if (m_mode == M_HALT) begin
            if (!halt && (step || run)) begin
                m_mode = step ? M_STEP : M_RUN;
                m_bp = 0; m_pend = 0;
            end
        end else begin
            if (ret) begin
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
                hit = bp_feature() == 1 && m_mode == M_RUN && bpe && npc == bpa;
                if (m_mode == M_STEP || halt || m_pend || hit) begin
                    m_mode = M_HALT; m_pend = 0;
                end
                if (hit) m_bp = 1;
            end else if (halt) begin
                m_pend = 1;
            end
        end

        e.st   = m_mode;
        e.en   = (m_mode != M_HALT) ? 1 : 0;
        e.rst  = (m_mode == M_CRST) ? 1 : 0;
        e.cnt  = m_cnt;
        e.bp   = m_bp ? 1 : 0;
        e.inst = m_ram[fa];
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int fa);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, fa, 0, 0);
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state",       int'(state),       e.st);
            chk("core_en",     int'(core_en),     e.en);
            chk("core_rst",    int'(core_rst),    e.rst);
            chk("host_ack",    int'(host_ack),    e.ack);
            chk("host_nack",   int'(host_nack),   e.nack);
            chk("retired_cnt", int'(retired_cnt), e.cnt);
            chk("halted_bp",   int'(halted_bp),   e.bp);
            chk("core_inst",   int'(core_inst),   e.inst);
        end
    end

    initial begin
        int wait_cycles;
        for (int i = 0; i < 16; i++) m_ram[i] = 0;
        reset_p = 1'b1;
        cmd_reset = 0; cmd_halt = 0; cmd_step = 0; cmd_run = 0;
        host_we = 0; host_addr = 0; host_data = 0;
        core_retire = 0; core_next_pc = 0; core_fetch_addr = 4'd3;
        bp_en = 0; bp_addr = 0;
        #2;
        chk("rst_state",     int'(state),       M_HALT);
        chk("rst_core_en",   int'(core_en),     0);
        chk("rst_core_rst",  int'(core_rst),    1);
        chk("rst_ack",       int'(host_ack),    0);
        chk("rst_nack",      int'(host_nack),   0);
        chk("rst_cnt",       int'(retired_cnt), 0);
        chk("rst_halted_bp", int'(halted_bp),   0);
        chk("rst_inst",      int'(core_inst),   0);
        @(negedge clock);
        reset_p = 1'b0;

        // Program load in HALT, then read back word 1
        drive(0, 0, 0, 0, 1, 0, 'h19, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 'hF2, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 2, 'h90, 0, 0, 1, 0, 0);
        idle(1);

        // Write rejected while running
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 'hAB, 0, 0, 3, 0, 0);
        idle(3);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        idle(3); idle(3); idle(3);

        // Single step
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        idle(1); idle(1);

        // Halt during the retire cycle
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 3, 2, 0, 0);
        idle(3); idle(3);

        // Halt pending until next retire
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        idle(1);

        // Breakpoint at 2, then cmd_run clears halted_bp
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 1, 2);
        idle(2); idle(2);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 2);
        idle(2);

        // Saturation then mid-run controller reset
        for (int i = 0; i < 20; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        idle(5); idle(5); idle(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, h, s, ru, we, ret;
            r   = ($urandom_range(0, 39) == 0);
            h   = ($urandom_range(0, 9) == 0);
            s   = ($urandom_range(0, 7) == 0);
            ru  = ($urandom_range(0, 5) == 0);
            we  = ($urandom_range(0, 2) == 0);
            ret = (m_mode == M_RUN || m_mode == M_STEP) &&
                  ($urandom_range(0, 1) == 0);
            drive(r, h, s, ru, we, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), ret,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clock);
            wait_cycles++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
